// File: rtl/irq_pkg.sv
// irq_pkg: state encoding and id width helper shared by the interrupt controller
package irq_pkg;
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_REQ     = 2'd1;
  localparam logic [1:0] S_SERVICE = 2'd2;
  function automatic int id_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/irq_prio_enc.sv
// irq_prio_enc: lowest-index-wins priority encoder with valid flag
module irq_prio_enc #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  output logic [W-1:0] id,
  output logic         valid
);
  // scan from the top so the lowest set index is the last one written
  always_comb begin
    id = '0;
    for (int i = N - 1; i >= 0; i--)
      if (req[i]) id = W'(i);
    valid = |req;
  end
endmodule

// File: rtl/irq_controller.sv
// irq_controller: prioritised interrupt controller with req/ack/done handshake; IRQ_SYNC_EN adds 2-flop input synchronizers
module irq_controller
  import irq_pkg::*;
#(
  parameter int                   NUM_IRQ    = 4,
  parameter int                   ADDR_W     = 8,
  parameter logic [ADDR_W-1:0]    VEC_BASE   = 8'hF0,
  parameter int                   VEC_STRIDE = 4,
  parameter logic [NUM_IRQ-1:0]   EDGE_MASK  = {NUM_IRQ{1'b1}},
  localparam int                  ID_W       = id_w(NUM_IRQ)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic               mask_wr,
  input  logic [NUM_IRQ-1:0] mask_in,
  output logic [NUM_IRQ-1:0] mask_out,
  input  logic               irq_ack,
  input  logic               irq_done,
  output logic               irq_req,
  output logic [ADDR_W-1:0]  irq_vector,
  output logic [ID_W-1:0]    irq_id,
  output logic [NUM_IRQ-1:0] pending,
  output logic               busy
);
  logic [NUM_IRQ-1:0] irq_s, irq_prev, pend_r, mask_r, rise, clr, eligible;
  logic [1:0]         state;
  logic [ID_W-1:0]    enc_id;
  logic               enc_valid, ack_ok, take;
  logic [ADDR_W-1:0]  vec_next;
`ifdef IRQ_SYNC_EN
  logic [NUM_IRQ-1:0] sync1, sync2;
  // two-stage synchronizer for asynchronous interrupt sources
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= irq_in;
      sync2 <= sync1;
    end
  assign irq_s = sync2;
`else
  assign irq_s = irq_in;
`endif
  assign rise     = irq_s & ~irq_prev & EDGE_MASK;
  assign ack_ok   = state == S_REQ && irq_req && irq_ack;
  assign clr      = ack_ok ? NUM_IRQ'(1) << irq_id : '0;
  assign pending  = (pend_r & EDGE_MASK) | (irq_s & ~EDGE_MASK);
  assign eligible = pending & ~mask_r;
  assign take     = state == S_IDLE && enc_valid;
  assign vec_next = VEC_BASE + ADDR_W'(int'(enc_id) * VEC_STRIDE);
  assign mask_out = mask_r;
  assign busy     = state != S_IDLE;

  irq_prio_enc #(.N(NUM_IRQ), .W(ID_W)) u_enc (
    .req   (eligible),
    .id    (enc_id),
    .valid (enc_valid)
  );

  // edge history, sticky edge pending (a new edge beats an ack clear) and mask
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      irq_prev <= '0;
      pend_r   <= '0;
      mask_r   <= '1;
    end else begin
      irq_prev <= irq_s;
      pend_r   <= (pend_r & ~clr) | rise;
      mask_r   <= mask_wr ? mask_in : mask_r;
    end

  // handshake FSM; id/vector latched on request and held until the handler returns
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state      <= S_IDLE;
      irq_req    <= 1'b0;
      irq_id     <= '0;
      irq_vector <= '0;
    end else begin
      state      <= take ? S_REQ : ack_ok ? S_SERVICE :
                    (state == S_SERVICE && irq_done) ? S_IDLE : state;
      irq_req    <= state == S_REQ && !ack_ok;
      irq_id     <= take ? enc_id : (state == S_SERVICE && irq_done) ? '0 : irq_id;
      irq_vector <= take ? vec_next : (state == S_SERVICE && irq_done) ? '0 : irq_vector;
    end
endmodule

// File: tb/tb_irq_controller.sv
// tb_irq_controller: directed checks of two controller instances (all-edge F0 base, level ch0 FC base)
module tb_irq_controller;
`ifdef IRQ_SYNC_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 2;
`endif
  logic       clk = 0, reset = 0;
  logic [3:0] irq_a = 0, mask_in_a = 0, mask_out_a, pend_a;
  logic       mask_wr_a = 0, ack_a = 0, done_a = 0, req_a, busy_a;
  logic [7:0] vec_a;
  logic [1:0] id_a;
  logic [3:0] irq_b = 0, mask_in_b = 0, mask_out_b, pend_b;
  logic       mask_wr_b = 0, ack_b = 0, done_b = 0, req_b, busy_b;
  logic [7:0] vec_b;
  logic [1:0] id_b;
  int tot = 0, bad = 0, n;

  always #5 clk = ~clk;

  irq_controller #(.NUM_IRQ(4), .ADDR_W(8), .VEC_BASE(8'hF0), .VEC_STRIDE(4), .EDGE_MASK(4'hF)) dut_a (
    .clk(clk), .reset(reset), .irq_in(irq_a), .mask_wr(mask_wr_a), .mask_in(mask_in_a),
    .mask_out(mask_out_a), .irq_ack(ack_a), .irq_done(done_a), .irq_req(req_a),
    .irq_vector(vec_a), .irq_id(id_a), .pending(pend_a), .busy(busy_a));

  irq_controller #(.NUM_IRQ(4), .ADDR_W(8), .VEC_BASE(8'hFC), .VEC_STRIDE(4), .EDGE_MASK(4'hE)) dut_b (
    .clk(clk), .reset(reset), .irq_in(irq_b), .mask_wr(mask_wr_b), .mask_in(mask_in_b),
    .mask_out(mask_out_b), .irq_ack(ack_b), .irq_done(done_b), .irq_req(req_b),
    .irq_vector(vec_b), .irq_id(id_b), .pending(pend_b), .busy(busy_b));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tot++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int k = 1);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_req(input bit b, output int cnt);
    cnt = 0;
    do begin
      step();
      cnt++;
    end while (!(b ? req_b : req_a) && cnt < 12);
  endtask

  task automatic ack_done_a;
    ack_a = 1; step(); ack_a = 0;
    done_a = 1; step(); done_a = 0;
  endtask

  initial begin
    step(2);
    chk("rst_req", req_a, 0); chk("rst_vec", vec_a, 0); chk("rst_id", id_a, 0);
    chk("rst_busy", busy_a, 0); chk("rst_mask", mask_out_a, 4'hF); chk("rst_pend", pend_a, 0);
    reset = 1;
    irq_a = 4'b0010;
    step(3 + LAT);
    chk("masked_noreq", req_a, 0); chk("masked_idle", busy_a, 0); chk("masked_pend", pend_a, 4'h2);
    mask_wr_a = 1; mask_in_a = 0; step(); mask_wr_a = 0;
    chk("mask_clr", mask_out_a, 0); chk("mask_idle", busy_a, 0);
    step();
    chk("req_busy", busy_a, 1); chk("req_lag", req_a, 0); chk("req_id1", id_a, 1); chk("req_vec1", vec_a, 8'hF4);
    step();
    chk("req_up", req_a, 1);
    ack_a = 1; step(); ack_a = 0;
    chk("ack_req", req_a, 0); chk("ack_pend", pend_a, 0); chk("ack_busy", busy_a, 1);
    done_a = 1; step(); done_a = 0;
    chk("done_idle", busy_a, 0);
    irq_a = 0; step(LAT + 1);
    // single edge on ch2 with latency measurement, then reset mid-service
    irq_a = 4'b0100;
    wait_req(0, n);
    chk("lat_ch2", n, LAT + 1); chk("id_ch2", id_a, 2); chk("vec_ch2", vec_a, 8'hF8);
    ack_a = 1; step(); ack_a = 0;
    chk("ack_pend2", pend_a, 0); chk("svc_busy", busy_a, 1);
    irq_a = 0;
    reset = 0; #1;
    chk("mrst_req", req_a, 0); chk("mrst_id", id_a, 0); chk("mrst_vec", vec_a, 0);
    chk("mrst_busy", busy_a, 0); chk("mrst_mask", mask_out_a, 4'hF);
    step(); reset = 1; step(3);
    chk("mrst_stay", busy_a, 0);
    mask_wr_a = 1; mask_in_a = 0; step(); mask_wr_a = 0;
    mask_wr_b = 1; mask_in_b = 0; step(); mask_wr_b = 0;
    irq_a = 4'b0100;
    wait_req(0, n);
    chk("lat2_ch2", n, LAT + 1); chk("id2_ch2", id_a, 2); chk("vec2_ch2", vec_a, 8'hF8);
    ack_done_a();
    chk("done2_idle", busy_a, 0);
    irq_a = 0; step(LAT + 1);
    // simultaneous edges on ch1 and ch3
    irq_a = 4'b1010;
    wait_req(0, n);
    chk("both_id1", id_a, 1); chk("both_vec1", vec_a, 8'hF4); chk("both_pend", pend_a, 4'hA);
    ack_a = 1; step(); ack_a = 0;
    chk("both_pend3", pend_a, 4'h8);
    done_a = 1; step(); done_a = 0;
    step(2);
    chk("ch3_req", req_a, 1); chk("ch3_id", id_a, 3); chk("ch3_vec", vec_a, 8'hFC);
    ack_done_a();
    irq_a = 0; step(LAT + 1);
    // no preemption: ch0 edge and mask change while ch2 is requesting
    irq_a = 4'b0100;
    wait_req(0, n);
    irq_a = 4'b0101; mask_wr_a = 1; mask_in_a = 4'h4; step(); mask_wr_a = 0;
    step(LAT);
    chk("lock_id", id_a, 2); chk("lock_vec", vec_a, 8'hF8); chk("lock_req", req_a, 1);
    chk("lock_mask", mask_out_a, 4'h4); chk("lock_pend", pend_a, 4'h5);
    ack_a = 1; step(); ack_a = 0;
    chk("lock_ackpend", pend_a, 4'h1);
    done_a = 1; step(); done_a = 0;
    step(2);
    chk("next_req", req_a, 1); chk("next_id", id_a, 0); chk("next_vec", vec_a, 8'hF0);
    ack_done_a();
    irq_a = 0; mask_wr_a = 1; mask_in_a = 0; step(LAT + 1); mask_wr_a = 0;
    // new edge on the channel being acked keeps it pending
    irq_a = 4'b0100;
    wait_req(0, n);
    irq_a = 0; step(LAT);
    irq_a = 4'b0100; ack_a = 1; step(LAT); ack_a = 0;
    chk("setwin_pend", pend_a, 4'h4); chk("setwin_busy", busy_a, 1); chk("setwin_req", req_a, 0);
    done_a = 1; step(); done_a = 0;
    step(2);
    chk("setwin_rereq", req_a, 1); chk("setwin_id", id_a, 2);
    ack_done_a();
    irq_a = 0;
    // level ch0 on dut_b is re-raised after done until masked
    irq_b = 4'b0001; #1;
    chk("lvl_pend", pend_b, 4'h1);
    step();
    chk("lvl_busy", busy_b, 1); chk("lvl_id", id_b, 0); chk("lvl_vec", vec_b, 8'hFC);
    step();
    chk("lvl_req", req_b, 1);
    ack_b = 1; step(); ack_b = 0;
    chk("lvl_ackpend", pend_b, 4'h1);
    done_b = 1; step(); done_b = 0;
    chk("lvl_idle", busy_b, 0);
    step(2);
    chk("lvl_rereq", req_b, 1);
    ack_b = 1; step(); ack_b = 0;
    mask_wr_b = 1; mask_in_b = 4'h1; step(); mask_wr_b = 0;
    chk("lvl_svc_kept", busy_b, 1);
    done_b = 1; step(); done_b = 0;
    step(3);
    chk("lvl_masked_busy", busy_b, 0); chk("lvl_masked_req", req_b, 0);
    // vector wrap: base FC, id 1 -> 00
    irq_b = 4'b0011;
    wait_req(1, n);
    chk("wrap_lat", n, LAT + 1); chk("wrap_id", id_b, 1); chk("wrap_vec", vec_b, 8'h00);
    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end
endmodule
